cpsr_cond_unit: RTL
===================

# cpsr_cond_unit

Multi-lane condition-evaluation unit with an owned CPSR flag register and a flag-hazard scoreboard. Holds the architectural N/Z/C/V flags, applies masked flag writebacks, and evaluates a 4-bit ARM condition code for each of LANES issue lanes, returning registered execute/skip decisions one cycle later. Sits between decode/issue and execute: issue presents condition codes, execute writes flags back, and the unit stalls condition evaluation while a flag-setting instruction is still in flight.

## Interface
- LANES, 2, number of independent condition-evaluation lanes (1..4)
- MAXPEND, 3, maximum in-flight flag-setting instructions tracked (1..7)
- BYPASS, 1, 1: same-cycle flag writeback is forwarded into evaluation; 0: evaluation uses registered CPSR only

- clk  in  1  sole clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- cond_valid  in  LANES  per-lane request to evaluate a condition
- cond_code  in  4*LANES  lane i code at [4i+3:4i]
- cond_ready  out  1  evaluation accepted this cycle (shared by all lanes)
- exec_out  out  LANES  registered decision: 1 = execute, 0 = skip
- exec_valid  out  LANES  registered lane-valid for exec_out
- stall  in  1  hold exec_out/exec_valid, accept nothing
- flush  in  1  clear exec_valid and scoreboard
- pend_inc  in  1  issue of one flag-setting instruction
- flags_we  in  1  flag writeback strobe (retires one pending entry)
- flags_mask  in  4  per-flag write enable, bit order V=0, C=1, Z=2, N=3
- flags_in  in  4  new flag values, same bit order
- cpsr_out  out  4  current registered flags
- pend_full  out  1  scoreboard count == MAXPEND

## Operation
- Code decode: sel = code[0], grp = code[3:1]. grp 000: sel^Z; 001: sel^C; 010: sel^N; 011: sel^V; 100: sel^(C & ~Z); 101: sel^~(N^V); 110: sel^(~Z & ~(N^V)); 111: always 1 (sel ignored).
- Flag register: on flags_we, each flag with mask bit 1 takes flags_in, others hold. flags_we with mask 0000 still retires a pending entry.
- Evaluation flags: BYPASS=1 and flags_we: masked merge of flags_in over CPSR; otherwise registered CPSR.
- Scoreboard count P (width clog2(MAXPEND+1)): pend_inc only → P+1; flags_we only → P-1; both → unchanged. pend_inc with pend_full and no flags_we is ignored (P stays MAXPEND). flags_we with P==0 is a flag write with no count change (no underflow).
- cond_ready = ~stall & (P==0 | (BYPASS & flags_we & P==1 & ~pend_inc)).
- Accept: when cond_ready, next exec_valid[i] = cond_valid[i], exec_out[i] = decision of lane i (0 when lane invalid). When not ready and not stall: exec_valid clears to 0 (bubble). When stall: exec_valid/exec_out hold.
- All lanes evaluate the same flag snapshot; lanes have no intra-bundle ordering.
- flush (priority over stall and accept): exec_valid ← 0, P ← 0; flag writeback in the same cycle still applies.

## Timing
- Reset (reset_n low at edge): cpsr_out 0000, P 0, exec_valid 0, exec_out 0, pend_full 0 (1 if MAXPEND would be 0, illegal). cond_ready combinationally 1 once reset_n high and stall low.
- Latency: cond_code in cycle t → exec_out/exec_valid valid after edge t+1; throughput one bundle per cycle.
- flags_we at t → cpsr_out updated after edge t; visible to evaluation at t itself only when BYPASS=1.
- Reset mid-operation discards in-flight bundle, pending count and flags.

## Test plan
- Reset, then flags_we mask 1111 flags_in 0100 (Z=1); next cycle lane0 code 0000, lane1 code 0001 → exec_out 01 (lane0 1, lane1 0), exec_valid 11 one cycle later.
- Flags N=1 V=0 Z=0: codes 1010 (GE) → 0, 1011 (LT) → 1, 1100 (GT) → 0, 1101 (LE) → 1, 1110 and 1111 → 1; repeat across all 16 flag combinations against the decode table.
- Masked write: cpsr 1111, flags_we mask 0011 flags_in 0000 → cpsr_out 1100.
- Hazard: pend_inc at t, cond_valid at t+1 → cond_ready 0, exec_valid 0; flags_we with Z=1 at t+3 → BYPASS=1 accepts at t+3, code 0000 yields exec_out 1 at t+4; BYPASS=0 accepts at t+4.
- Scoreboard edges (MAXPEND=3): four pend_inc → P=3, pend_full 1, fourth ignored; pend_inc+flags_we same cycle → P stays 3; flags_we at P=0 → P stays 0.
- stall holds exec_out for 3 cycles unchanged; flush during stall → exec_valid 0, P 0 next cycle, cond_ready 1 after stall drops.

Source files
------------

// File: rtl/cpsr_cond_unit_if.sv
// Issue/execute-side bundle for the condition-evaluation unit.
// master = the pipeline driving requests and flag writebacks,
// slave  = the condition unit itself.
interface cpsr_cond_unit_if #(
   parameter int LANES = 2
);
   logic [LANES-1:0]   cond_valid;
   logic [4*LANES-1:0] cond_code;
   logic               cond_ready;
   logic [LANES-1:0]   exec_out;
   logic [LANES-1:0]   exec_valid;
   logic               stall;
   logic               flush;
   logic               pend_inc;
   logic               flags_we;
   logic [3:0]         flags_mask;
   logic [3:0]         flags_in;
   logic [3:0]         cpsr_out;
   logic               pend_full;

   modport master (
      output cond_valid, cond_code, stall, flush, pend_inc,
             flags_we, flags_mask, flags_in,
      input  cond_ready, exec_out, exec_valid, cpsr_out, pend_full
   );

   modport slave (
      input  cond_valid, cond_code, stall, flush, pend_inc,
             flags_we, flags_mask, flags_in,
      output cond_ready, exec_out, exec_valid, cpsr_out, pend_full
   );
endinterface

// File: rtl/cpsr_cond_unit.sv
// Multi-lane ARM condition evaluator with an owned N/Z/C/V register and a
// scoreboard of in-flight flag-setting instructions. Evaluation is held off
// while any flag producer is outstanding, except when the last one is
// writing back this very cycle and forwarding is enabled.
// Flag bit order everywhere: V=0, C=1, Z=2, N=3.
module cpsr_cond_unit #(
   parameter int LANES   = 2,
   parameter int MAXPEND = 3,
   parameter int BYPASS  = 1
) (
   input logic               clk,
   input logic               reset_n,
   cpsr_cond_unit_if.slave   bus
);
   localparam int   PW        = (MAXPEND < 1) ? 1 : $clog2(MAXPEND + 1);
   localparam logic BYPASS_EN = (BYPASS != 0);

   logic [3:0]       cpsr_reg, cpsr_next;
   logic [PW-1:0]    pend_reg, pend_next;
   logic [LANES-1:0] exec_out_reg, exec_out_next;
   logic [LANES-1:0] exec_valid_reg, exec_valid_next;

   logic [3:0]       merged_flags;
   logic [3:0]       eval_flags;
   logic             pend_zero, pend_one, pend_full_int;
   logic             ready;
   logic [LANES-1:0] decision;

   // Decode one condition code against a flag snapshot.
   // Odd codes invert the even-code predicate; group 111 is always-true.
   function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
      logic n, z, c, v, raw;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      case (code[3:1])
         3'b000:  raw = z;
         3'b001:  raw = c;
         3'b010:  raw = n;
         3'b011:  raw = v;
         3'b100:  raw = c & ~z;
         3'b101:  raw = ~(n ^ v);
         3'b110:  raw = ~z & ~(n ^ v);
         default: raw = 1'b0;
      endcase
      return (code[3:1] == 3'b111) ? 1'b1 : (raw ^ code[0]);
   endfunction

   // Masked merge of the incoming writeback over the held flags; also the
   // forwarded snapshot when bypass is enabled.
   assign merged_flags  = (bus.flags_in & bus.flags_mask) | (cpsr_reg & ~bus.flags_mask);
   assign eval_flags    = (BYPASS_EN && bus.flags_we) ? merged_flags : cpsr_reg;

   assign pend_zero     = (pend_reg == '0);
   assign pend_one      = (pend_reg == PW'(1));
   assign pend_full_int = (pend_reg == PW'(MAXPEND));

   // Ready when nothing is outstanding, or the single outstanding producer
   // retires now and its flags are forwarded (a new producer issuing in the
   // same cycle keeps the hazard alive).
   assign ready = ~bus.stall &
                  (pend_zero | (BYPASS_EN & bus.flags_we & pend_one & ~bus.pend_inc));

   // All lanes see the same snapshot; no ordering between lanes.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign decision[gi] = cond_eval(bus.cond_code[4*gi +: 4], eval_flags);
   end

   // Next-state for flags, scoreboard and the registered decision stage.
   always_comb begin
      cpsr_next       = bus.flags_we ? merged_flags : cpsr_reg;

      pend_next       = pend_reg;
      if (bus.flush) begin
         pend_next = '0;
      end else if (bus.pend_inc && !bus.flags_we && !pend_full_int) begin
         pend_next = pend_reg + PW'(1);
      end else if (bus.flags_we && !bus.pend_inc && !pend_zero) begin
         pend_next = pend_reg - PW'(1);
      end

      exec_out_next   = exec_out_reg;
      exec_valid_next = exec_valid_reg;
      if (bus.flush) begin
         exec_valid_next = '0;
      end else if (bus.stall) begin
         exec_valid_next = exec_valid_reg;
      end else if (ready) begin
         exec_valid_next = bus.cond_valid;
         exec_out_next   = decision & bus.cond_valid;
      end else begin
         exec_valid_next = '0;
         exec_out_next   = '0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cpsr_reg       <= '0;
         pend_reg       <= '0;
         exec_out_reg   <= '0;
         exec_valid_reg <= '0;
      end else begin
         cpsr_reg       <= cpsr_next;
         pend_reg       <= pend_next;
         exec_out_reg   <= exec_out_next;
         exec_valid_reg <= exec_valid_next;
      end
   end

   assign bus.cond_ready = ready;
   assign bus.exec_out   = exec_out_reg;
   assign bus.exec_valid = exec_valid_reg;
   assign bus.cpsr_out   = cpsr_reg;
   assign bus.pend_full  = pend_full_int;
endmodule
